// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - op codes, size/state encodings and op decode helpers
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic size_e op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SIZE_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_HALF;
      default:                          return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane replication and load byte/half extract with sign/zero extend
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wdata_rep,
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_byte_sel,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_size)
      SIZE_BYTE: o_wdata_rep = {4{i_wdata[7:0]}};
      SIZE_HALF: o_wdata_rep = {2{i_wdata[15:0]}};
      default:   o_wdata_rep = i_wdata;
    endcase
  end

  always_comb begin
    case (i_byte_sel)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_byte_sel[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_op)
      EXE_LB_OP:  o_load_data = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_load_data = {24'd0, w_byte};
      EXE_LH_OP:  o_load_data = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_load_data = {16'd0, w_half};
      default:    o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data bus controller; MEM_ADDR_CHECK_EN enables alignment exceptions
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  alucontrol,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_e      r_state;
  state_e      w_next_state;
  logic [7:0]  r_op;
  logic        r_done;
  logic [31:0] r_rdata_out;
  logic        r_data_req;
  logic        r_data_wr;
  size_e       r_data_size;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_wdata;

  logic        w_is_mem;
  logic        w_is_store;
  size_e       w_size;
  logic        w_misaligned;
  logic        w_can_accept;
  logic        w_accept;
  logic        w_addr_err;
  logic        w_complete;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_load_data;

  assign w_is_mem   = is_mem_op(alucontrol);
  assign w_is_store = is_store_op(alucontrol);
  assign w_size     = op_size(alucontrol);

`ifdef MEM_ADDR_CHECK_EN
  always_comb begin
    case (w_size)
      SIZE_HALF: w_misaligned = addr[0];
      SIZE_WORD: w_misaligned = |addr[1:0];
      default:   w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // start is still high in the done cycle; r_done keeps it from being taken twice
  assign w_can_accept = (r_state == ST_IDLE) & start & w_is_mem & ~r_done & ~flush;
  assign w_accept     = w_can_accept & ~w_misaligned;
  assign w_addr_err   = w_can_accept & w_misaligned;
  assign w_complete   = (r_state == ST_WAIT) & data_data_ok & ~flush;

  assign stall = (r_state != ST_IDLE) | w_accept;

  mem_align u_mem_align (
    .i_size      (w_size),
    .i_wdata     (wdata_in),
    .o_wdata_rep (w_wdata_rep),
    .i_op        (r_op),
    .i_byte_sel  (r_data_addr[1:0]),
    .i_rdata     (data_rdata),
    .o_load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_REQ;
      // a request accepted in the flush cycle is still in flight and must be drained
      ST_REQ: begin
        if (flush)             w_next_state = data_addr_ok ? ST_DRAIN : ST_IDLE;
        else if (data_addr_ok) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_data_ok) w_next_state = ST_IDLE;
        else if (flush)   w_next_state = ST_DRAIN;
      end
      ST_DRAIN: if (data_data_ok) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_done       <= 1'b0;
      r_rdata_out  <= '0;
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= SIZE_BYTE;
      r_data_addr  <= '0;
      r_data_wdata <= '0;
    end else begin
      r_done <= w_complete | w_addr_err;
      if (w_accept) begin
        r_op         <= alucontrol;
        r_data_req   <= 1'b1;
        r_data_wr    <= w_is_store;
        r_data_size  <= w_size;
        r_data_addr  <= addr;
        r_data_wdata <= w_wdata_rep;
      end else if ((r_state == ST_REQ) && (flush || data_addr_ok)) begin
        r_data_req <= 1'b0;
      end
      if (w_complete)      r_rdata_out <= r_data_wr ? 32'd0 : w_load_data;
      else if (w_addr_err) r_rdata_out <= 32'd0;
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  logic        r_adel;
  logic        r_ades;
  logic [31:0] r_bad_vaddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_adel      <= 1'b0;
      r_ades      <= 1'b0;
      r_bad_vaddr <= '0;
    end else begin
      r_adel <= w_addr_err & ~w_is_store;
      r_ades <= w_addr_err & w_is_store;
      if (w_addr_err) r_bad_vaddr <= addr;
    end
  end

  assign adel      = r_adel;
  assign ades      = r_ades;
  assign bad_vaddr = r_bad_vaddr;
`else
  assign adel      = 1'b0;
  assign ades      = 1'b0;
  assign bad_vaddr = '0;
`endif

  assign done       = r_done;
  assign rdata_out  = r_rdata_out;
  assign data_req   = r_data_req;
  assign data_wr    = r_data_wr;
  assign data_size  = r_data_size;
  assign data_addr  = r_data_addr;
  assign data_wdata = r_data_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a bench-driven bus slave
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  alucontrol = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata_in = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] rdata_out;
  logic        adel;
  logic        ades;
  logic [31:0] bad_vaddr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .alucontrol(alucontrol), .addr(addr),
    .wdata_in(wdata_in), .flush(flush), .stall(stall), .done(done),
    .rdata_out(rdata_out), .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  // every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_done rdata_out=%h adel=%b ades=%b (no completion expected)",
                 rdata_out, adel, ades);
      end else begin
        e = sb.pop_front();
        if (rdata_out !== e.rdata || adel !== e.adel || ades !== e.ades ||
            ((e.adel | e.ades) && bad_vaddr !== e.bad)) begin
          n_errors++;
          $display("FAIL done_result got rdata=%h adel=%b ades=%b bad=%h, expected rdata=%h adel=%b ades=%b bad=%h",
                   rdata_out, adel, ades, bad_vaddr, e.rdata, e.adel, e.ades, e.bad);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_size, input logic [31:0] exp_wdata,
                         input logic exp_wr, input int aok_wait, input int dok_wait);
    exp_t e;
    e.rdata = exp_rdata; e.adel = 1'b0; e.ades = 1'b0; e.bad = '0;
    sb.push_back(e);
    start = 1'b1; alucontrol = op; addr = a; wdata_in = wd;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++; $display("FAIL stall_accept op=%h stall=%b expected 1", op, stall);
    end
    step();
    n_checks++;
    if (data_req !== 1'b1 || stall !== 1'b1 || data_addr !== a || data_size !== exp_size ||
        data_wr !== exp_wr || data_wdata !== exp_wdata) begin
      n_errors++;
      $display("FAIL bus_fields op=%h got req=%b stall=%b addr=%h size=%0d wr=%b wdata=%h, expected 1 1 %h %0d %b %h",
               op, data_req, stall, data_addr, data_size, data_wr, data_wdata, a, exp_size, exp_wr, exp_wdata);
    end
    for (int i = 0; i < aok_wait; i++) begin
      data_rdata = $urandom;
      step();
      n_checks++;
      if (data_req !== 1'b1 || data_addr !== a) begin
        n_errors++; $display("FAIL req_held req=%b addr=%h expected 1 %h", data_req, data_addr, a);
      end
    end
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    n_checks++;
    if (data_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
      n_errors++; $display("FAIL wait_state req=%b stall=%b done=%b expected 0 1 0", data_req, stall, done);
    end
    for (int i = 0; i < dok_wait; i++) begin
      data_rdata = $urandom;
      step();
    end
    data_rdata = rd; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0; data_rdata = $urandom;
    n_checks++;
    if (done !== 1'b1 || stall !== 1'b0) begin
      n_errors++; $display("FAIL done_pulse done=%b stall=%b expected 1 0", done, stall);
    end
    start = 1'b0;
    step();
    n_checks++;
    if (done !== 1'b0 || data_req !== 1'b0) begin
      n_errors++; $display("FAIL done_one_cycle done=%b req=%b expected 0 0", done, data_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b0 || rdata_out !== 32'd0 || adel !== 1'b0 || ades !== 1'b0 ||
        bad_vaddr !== 32'd0 || data_req !== 1'b0 || data_wr !== 1'b0 || data_size !== 2'd0 ||
        data_addr !== 32'd0 || data_wdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_outputs stall=%b done=%b rdata=%h req=%b addr=%h expected all 0",
                           stall, done, rdata_out, data_req, data_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw_basic();
    run_txn(EXE_LW_OP, 32'h100, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'd2, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_loads();
    run_txn(EXE_LB_OP,  32'h103, 32'd0, 32'h80FF_7F01, 32'hFFFF_FF80, 2'd0, 32'd0, 1'b0, 2, 1);
    run_txn(EXE_LBU_OP, 32'h103, 32'd0, 32'h80FF_7F01, 32'h0000_0080, 2'd0, 32'd0, 1'b0, 0, 3);
    run_txn(EXE_LB_OP,  32'h101, 32'd0, 32'h80FF_7F01, 32'h0000_007F, 2'd0, 32'd0, 1'b0, 1, 0);
    run_txn(EXE_LH_OP,  32'h102, 32'd0, 32'h8001_1234, 32'hFFFF_8001, 2'd1, 32'd0, 1'b0, 0, 0);
    run_txn(EXE_LHU_OP, 32'h102, 32'd0, 32'h8001_1234, 32'h0000_8001, 2'd1, 32'd0, 1'b0, 1, 2);
    run_txn(EXE_LH_OP,  32'h100, 32'd0, 32'h8001_F234, 32'hFFFF_F234, 2'd1, 32'd0, 1'b0, 0, 1);
  endtask

  task automatic test_stores();
    run_txn(EXE_SB_OP, 32'h201, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 2'd0, 32'h7878_7878, 1'b1, 0, 0);
    run_txn(EXE_SH_OP, 32'h202, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 2'd1, 32'h5678_5678, 1'b1, 1, 1);
    run_txn(EXE_SW_OP, 32'h204, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 2'd2, 32'h1234_5678, 1'b1, 0, 2);
  endtask

  task automatic test_misaligned();
`ifdef MEM_ADDR_CHECK_EN
    exp_t e;
    e.rdata = 32'd0; e.adel = 1'b1; e.ades = 1'b0; e.bad = 32'h102;
    sb.push_back(e);
    start = 1'b1; alucontrol = EXE_LW_OP; addr = 32'h102;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL misaligned_no_stall stall=%b expected 0", stall);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || adel !== 1'b1 || bad_vaddr !== 32'h102 || data_req !== 1'b0) begin
      n_errors++; $display("FAIL adel_cycle1 done=%b adel=%b bad=%h req=%b expected 1 1 00000102 0",
                           done, adel, bad_vaddr, data_req);
    end
    start = 1'b0;
    step();
    n_checks++;
    if (done !== 1'b0 || data_req !== 1'b0) begin
      n_errors++; $display("FAIL adel_after done=%b req=%b expected 0 0", done, data_req);
    end
    e.adel = 1'b0; e.ades = 1'b1; e.bad = 32'h3;
    sb.push_back(e);
    start = 1'b1; alucontrol = EXE_SH_OP; addr = 32'h3; wdata_in = 32'hAABB_CCDD;
    step();
    n_checks++;
    if (done !== 1'b1 || ades !== 1'b1 || adel !== 1'b0 || data_req !== 1'b0) begin
      n_errors++; $display("FAIL ades_cycle1 done=%b ades=%b adel=%b req=%b expected 1 1 0 0",
                           done, ades, adel, data_req);
    end
    start = 1'b0;
    step();
`else
    run_txn(EXE_LW_OP, 32'h102, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'd2, 32'd0, 1'b0, 0, 0);
    run_txn(EXE_SH_OP, 32'h3, 32'hAABB_CCDD, 32'd0, 32'd0, 2'd1, 32'hCCDD_CCDD, 1'b1, 0, 0);
`endif
  endtask

  task automatic test_non_mem();
    start = 1'b1; alucontrol = 8'b0010_0000; addr = 32'h500;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL non_mem_stall stall=%b expected 0", stall);
    end
    step(); step();
    n_checks++;
    if (data_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL non_mem_ignored req=%b done=%b stall=%b expected 0 0 0", data_req, done, stall);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_flush();
    // flush while waiting for data: drained, silent, then a normal LW
    start = 1'b1; alucontrol = EXE_LW_OP; addr = 32'h300;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1; start = 1'b0;
    step();
    flush = 1'b0;
    n_checks++;
    if (stall !== 1'b1 || done !== 1'b0 || data_req !== 1'b0) begin
      n_errors++; $display("FAIL drain_entry stall=%b done=%b req=%b expected 1 0 0", stall, done, data_req);
    end
    step();
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++; $display("FAIL drain_hold stall=%b expected 1", stall);
    end
    data_rdata = 32'h1111_2222; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL drain_exit stall=%b done=%b expected 0 0", stall, done);
    end
    step();
    run_txn(EXE_LW_OP, 32'h304, 32'd0, 32'h3333_4444, 32'h3333_4444, 2'd2, 32'd0, 1'b0, 0, 0);

    start = 1'b1; alucontrol = EXE_LW_OP; addr = 32'h308;
    step();
    flush = 1'b1; start = 1'b0;
    step();
    flush = 1'b0;
    n_checks++;
    if (data_req !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL flush_req req=%b stall=%b expected 0 0", data_req, stall);
    end
    step(); step();
    n_checks++;
    if (data_req !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL flush_req_quiet req=%b done=%b expected 0 0", data_req, done);
    end

    start = 1'b1; alucontrol = EXE_LW_OP; addr = 32'h30C;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5555_6666; start = 1'b0;
    step();
    flush = 1'b0; data_data_ok = 1'b0;
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL flush_with_data_ok stall=%b done=%b expected 0 0", stall, done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    run_txn(EXE_SW_OP,  32'h600, 32'hA5A5_0F0F, 32'd0, 32'd0, 2'd2, 32'hA5A5_0F0F, 1'b1, 0, 0);
    run_txn(EXE_LW_OP,  32'h600, 32'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 2'd2, 32'd0, 1'b0, 0, 0);
    run_txn(EXE_LBU_OP, 32'h602, 32'd0, 32'hA5A5_0F0F, 32'h0000_00A5, 2'd0, 32'd0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; alucontrol = EXE_SW_OP; addr = 32'h700; wdata_in = 32'h0BAD_F00D;
    step();
    n_checks++;
    if (data_req !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid_req req=%b expected 1", data_req);
    end
    rst = 1'b1; start = 1'b0;
    step();
    rst = 1'b0;
    n_checks++;
    if (data_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || rdata_out !== 32'd0 ||
        data_addr !== 32'd0 || data_wdata !== 32'd0 || data_wr !== 1'b0 || data_size !== 2'd0 ||
        adel !== 1'b0 || ades !== 1'b0 || bad_vaddr !== 32'd0) begin
      n_errors++; $display("FAIL reset_mid_outputs req=%b stall=%b done=%b rdata=%h addr=%h wdata=%h expected all 0",
                           data_req, stall, done, rdata_out, data_addr, data_wdata);
    end
    step();
    run_txn(EXE_LH_OP, 32'h702, 32'd0, 32'h7FFF_0000, 32'h0000_7FFF, 2'd1, 32'd0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_loads();
    test_stores();
    test_misaligned();
    test_non_mem();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drained pending=%0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
